pc_redirect_unit: RTL and testbench

PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

---
 rtl/pc_pkg.sv | 20 ++
 rtl/pc_redirect_unit_flush_counter.sv | 35 +++
 rtl/pc_redirect_unit.sv | 141 ++++++++++++++
 tb/tb_pc_redirect_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the PC redirect unit: fetch FSM states,
// instruction size, default reset vector and a target-alignment helper.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    REDIR = 2'd3
  } pc_state_e;

  localparam logic [31:0] INSTR_BYTES          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // Force a target onto an instruction boundary by clearing the low bits.
  function automatic logic [31:0] align_target(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_redirect_unit_flush_counter.sv
// Flush down-counter: load on an accepted redirect, count down to zero,
// report nonzero while the pipeline front end must be killed.
module flush_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  output logic       nonzero_o
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  // Reload wins over decrement so back-to-back redirects restart the window.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign nonzero_o = (cnt_q != 3'd0);

endmodule

// File: rtl/pc_redirect_unit.sv
// PC redirect unit: owns the fetch PC, sequences PC+4 / stall / redirect,
// holds a redirect target while instruction memory is busy, and drives a
// fixed-length flush after every accepted redirect.
// Optional build macro MISALIGN_CHECK_EN: realign misaligned redirect
// targets and pulse misaligned_o alongside the PC update.
module pc_redirect_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  input  logic        stall_i,
  input  logic        imem_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        imem_req_o,
  output logic        flush_o,
  output logic        redirect_pending_o,
  output logic        misaligned_o
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic        flush_load;
  logic [31:0] redirect_src;
  logic [31:0] load_addr;
  logic        load_misaligned;

  // Youngest redirect wins: a live REDIRECT overrides any held target.
  assign redirect_src = (state_q == REDIR && !redirect_i) ? pending_q : target_i;

`ifdef MISALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;

  // Realign the address that is about to become the PC and flag it.
  always_comb begin
    load_addr       = align_target(redirect_src);
    load_misaligned = (redirect_src[1:0] != 2'b00);
  end
`else
  // Targets go into the PC untouched; no misalignment reporting.
  always_comb begin
    load_addr       = redirect_src;
    load_misaligned = 1'b0;
  end
`endif

  // Fetch sequencing: redirect beats stall beats increment.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pending_d  = pending_q;
    flush_load = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH, WAIT: begin
        if (redirect_i) begin
          if (imem_ready_i) begin
            pc_d       = load_addr;
            flush_load = 1'b1;
            state_d    = FETCH;
          end else begin
            pending_d = target_i;
            state_d   = REDIR;
          end
        end else if (stall_i) begin
          state_d = state_q;
        end else if (imem_ready_i) begin
          pc_d    = pc_q + INSTR_BYTES;
          state_d = FETCH;
        end else begin
          state_d = WAIT;
        end
      end
      REDIR: begin
        if (imem_ready_i) begin
          pc_d       = load_addr;
          pending_d  = 32'd0;
          flush_load = 1'b1;
          state_d    = FETCH;
        end else begin
          pending_d = redirect_src;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Architectural state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= BOOT;
      pc_q      <= RESET_VECTOR;
      pending_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
    end
  end

`ifdef MISALIGN_CHECK_EN
  assign misaligned_d = flush_load & load_misaligned;

  // One-cycle pulse that lines up with the realigned PC.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign misaligned_o = misaligned_q;
`else
  assign misaligned_o = load_misaligned;
`endif

  flush_counter u_flush_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (flush_load),
    .load_val_i (FLUSH_LOAD),
    .nonzero_o  (flush_o)
  );

  assign pc_o               = pc_q;
  assign pc_plus4_o         = pc_q + INSTR_BYTES;
  assign imem_req_o         = (state_q != BOOT);
  assign redirect_pending_o = (state_q == REDIR);

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed vectors with literal
// expectations plus a behavioural model compared on every falling edge.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] target;
  logic        stall;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic        flush;
  logic        redirect_pending;
  logic        misaligned;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam int FC = 2;

  pc_redirect_unit #(
    .RESET_VECTOR (32'h0000_0000),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .redirect_i         (redirect),
    .target_i           (target),
    .stall_i            (stall),
    .imem_ready_i       (imem_ready),
    .pc_o               (pc),
    .pc_plus4_o         (pc_plus4),
    .imem_req_o         (imem_req),
    .flush_o            (flush),
    .redirect_pending_o (redirect_pending),
    .misaligned_o       (misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] m_loaded(input logic [31:0] t);
`ifdef MISALIGN_CHECK_EN
    return t & 32'hFFFF_FFFC;
`else
    return t;
`endif
  endfunction

  function automatic logic m_bad(input logic [31:0] t);
`ifdef MISALIGN_CHECK_EN
    return t[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  logic [31:0] m_pc;
  logic        m_running;
  logic        m_have_target;
  logic [31:0] m_target;
  int          m_flush_left;
  logic        m_mis;
  logic [31:0] m_want;

  // The target that would be taken this cycle: a fresh one beats a held one.
  assign m_want = redirect ? target : m_target;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc          <= 32'h0;
      m_running     <= 1'b0;
      m_have_target <= 1'b0;
      m_target      <= 32'h0;
      m_flush_left  <= 0;
      m_mis         <= 1'b0;
    end else begin
      m_flush_left <= (m_flush_left > 0) ? m_flush_left - 1 : 0;
      m_mis        <= 1'b0;
      if (!m_running) begin
        m_running <= 1'b1;
      end else if (redirect || m_have_target) begin
        if (imem_ready) begin
          m_pc          <= m_loaded(m_want);
          m_mis         <= m_bad(m_want);
          m_flush_left  <= FC;
          m_have_target <= 1'b0;
          m_target      <= 32'h0;
        end else begin
          m_target      <= m_want;
          m_have_target <= 1'b1;
        end
      end else if (!stall && imem_ready) begin
        m_pc <= m_pc + 32'd4;
      end
    end
  end

  // Compare process: all outputs against the model on every falling edge.
  always @(negedge clk) begin
    check("model_pc",       pc,                       m_pc);
    check("model_pc_plus4", pc_plus4,                 m_pc + 32'd4);
    check("model_imem_req", {31'd0, imem_req},        {31'd0, m_running});
    check("model_flush",    {31'd0, flush},           {31'd0, (m_flush_left != 0)});
    check("model_pending",  {31'd0, redirect_pending},{31'd0, m_have_target});
    check("model_misalign", {31'd0, misaligned},      {31'd0, m_mis});
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int flush_hits;

  initial begin
    rst = 1'b1; redirect = 1'b0; target = 32'h0; stall = 1'b0; imem_ready = 1'b1;
    repeat (2) tick();
    check("reset_pc", pc, 32'h0);
    check("reset_imem_req", {31'd0, imem_req}, 32'd0);
    check("reset_flush", {31'd0, flush}, 32'd0);

    // Boot sequence: no request in the first cycle, then 0,4,8,12.
    rst = 1'b0;
    #1;
    check("boot_imem_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("boot_pc0", pc, 32'h0);
    check("boot_req", {31'd0, imem_req}, 32'd1);
    tick(); check("seq_pc4",  pc, 32'h4);
    tick(); check("seq_pc8",  pc, 32'h8);
    tick(); check("seq_pc12", pc, 32'hC);
    tick(); check("seq_pc16", pc, 32'h10);

    // Immediate redirect from 0x10 to 0x100, flush exactly two cycles.
    redirect = 1'b1; target = 32'h100;
    tick(); redirect = 1'b0;
    check("redir_pc", pc, 32'h100);
    check("redir_flush1", {31'd0, flush}, 32'd1);
    tick(); check("redir_flush2", {31'd0, flush}, 32'd1);
    check("redir_pc_inc", pc, 32'h104);
    tick(); check("redir_flush_end", {31'd0, flush}, 32'd0);

    // Deferred redirect: memory busy for three cycles.
    redirect = 1'b1; target = 32'h200; imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("defer_pending", {31'd0, redirect_pending}, 32'd1);
      check("defer_pc_hold", pc, 32'h108);
    end
    redirect = 1'b0; imem_ready = 1'b1;
    tick();
    check("defer_pc", pc, 32'h200);
    check("defer_pending_clr", {31'd0, redirect_pending}, 32'd0);
    check("defer_flush1", {31'd0, flush}, 32'd1);
    tick(); check("defer_flush2", {31'd0, flush}, 32'd1);
    tick(); check("defer_flush_end", {31'd0, flush}, 32'd0);

    // Redirect overrides stall; stall alone holds the PC.
    stall = 1'b1; redirect = 1'b1; target = 32'h40;
    tick(); redirect = 1'b0;
    check("stall_redir_pc", pc, 32'h40);
    for (int i = 0; i < 4; i++) begin
      tick(); check("stall_hold", pc, 32'h40);
    end
    stall = 1'b0;

    // Memory not ready without redirect: PC holds, then resumes.
    imem_ready = 1'b0;
    tick(); check("wait_hold", pc, 32'h40);
    imem_ready = 1'b1;
    tick(); check("wait_resume", pc, 32'h44);

    // Back-to-back redirects: flush window restarts, three cycles total.
    flush_hits = 0;
    redirect = 1'b1; target = 32'h300;
    tick(); flush_hits += int'(flush);
    target = 32'h80;
    tick(); flush_hits += int'(flush);
    redirect = 1'b0;
    check("b2b_pc", pc, 32'h80);
    for (int i = 0; i < 3; i++) begin
      tick(); flush_hits += int'(flush);
    end
    check("b2b_flush_total", flush_hits, 32'd3);

    // Increment wrap at the top of the address space.
    redirect = 1'b1; target = 32'hFFFF_FFFC;
    tick(); redirect = 1'b0;
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0);
    tick(); check("wrap_pc0", pc, 32'h0);

    // Misaligned target.
    redirect = 1'b1; target = 32'h102;
    tick(); redirect = 1'b0;
`ifdef MISALIGN_CHECK_EN
    check("mis_pc", pc, 32'h100);
    check("mis_pulse", {31'd0, misaligned}, 32'd1);
`else
    check("mis_pc", pc, 32'h102);
    check("mis_pulse", {31'd0, misaligned}, 32'd0);
`endif
    tick(); check("mis_pulse_end", {31'd0, misaligned}, 32'd0);

    // Reset in the middle of a flush clears it at once.
    redirect = 1'b1; target = 32'h500;
    tick(); redirect = 1'b0;
    check("pre_reset_flush", {31'd0, flush}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_reset_flush", {31'd0, flush}, 32'd0);
    check("async_reset_pc", pc, 32'h0);
    check("async_reset_req", {31'd0, imem_req}, 32'd0);
    tick();

    // Redirect presented during BOOT is ignored.
    @(negedge clk);
    rst = 1'b0; redirect = 1'b1; target = 32'h900;
    tick(); redirect = 1'b0;
    check("boot_redir_ignored", pc, 32'h0);
    check("boot_to_fetch", {31'd0, imem_req}, 32'd1);
    tick(); check("post_boot_pc", pc, 32'h4);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
